// File: rtl/riscv_pkg.sv
// Shared definitions for the RISCV_2 multi-cycle controller: opcodes,
// ALUSel codes, FSM state encoding, writeback/PC select codes, the decoded
// instruction class and the decoder result bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_ADDI = 4'b0010;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4     = 2'd0;
  localparam logic [1:0] PC_ALU       = 2'd1;
  localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE  = 4'd0,
    CL_OP    = 4'd1,
    CL_ADDI  = 4'd2,
    CL_AUIPC = 4'd3,
    CL_LW    = 4'd4,
    CL_SW    = 4'd5,
    CL_BEQ   = 4'd6,
    CL_BNE   = 4'd7,
    CL_BLT   = 4'd8,
    CL_BLTU  = 4'd9,
    CL_JAL   = 4'd10,
    CL_JALR  = 4'd11
  } class_e;

  typedef struct packed {
    logic       legal;
    class_e     cls;
    logic [3:0] alu_sel;
    logic       src_a;
    logic       src_b;
    logic [1:0] wb_sel;
  } dec_t;

  function automatic logic is_branch(class_e c);
    return (c == CL_BEQ) || (c == CL_BNE) || (c == CL_BLT) || (c == CL_BLTU);
  endfunction

endpackage

// File: rtl/riscv_mc_control_if.sv
// Controller <-> datapath/memory bundle.
//   master : the control FSM (drives strobes/selects, reads ir, readies, cmp)
//   slave  : datapath + memories (drive ir, readies, comparator flags)
interface riscv_mc_control_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] ir;
  logic            imem_ready;
  logic            dmem_ready;
  logic            cmp_eq;
  logic            cmp_lt;
  logic            cmp_ltu;

  logic            imem_req;
  logic            ir_we;
  logic [3:0]      ALUSel;
  logic            alu_src_a;
  logic            alu_src_b;
  logic            mem_re;
  logic            mem_we;
  logic            reg_we;
  logic [1:0]      wb_sel;
  logic            pc_we;
  logic [1:0]      pc_src;
  logic            illegal;
  logic            bus_err;
  logic [2:0]      state_o;

  modport master (
    input  ir, imem_ready, dmem_ready, cmp_eq, cmp_lt, cmp_ltu,
    output imem_req, ir_we, ALUSel, alu_src_a, alu_src_b, mem_re, mem_we,
           reg_we, wb_sel, pc_we, pc_src, illegal, bus_err, state_o
  );

  modport slave (
    output ir, imem_ready, dmem_ready, cmp_eq, cmp_lt, cmp_ltu,
    input  imem_req, ir_we, ALUSel, alu_src_a, alu_src_b, mem_re, mem_we,
           reg_we, wb_sel, pc_we, pc_src, illegal, bus_err, state_o
  );
endinterface

// File: rtl/riscv_ctrl_decode.sv
// Purely combinational instruction classifier.
//   opcode_i/funct3_i/funct7_i : instruction fields from IR
//   dec_o                      : legal flag, class, ALUSel, operand selects, wb_sel
module riscv_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    unique case (opcode_i)
      OPC_OP: begin
        if (funct3_i == 3'b000 && funct7_i == 7'b0000000) begin
          dec_o.legal   = 1'b1;
          dec_o.cls     = CL_OP;
          dec_o.alu_sel = ALU_ADD;
        end else if (funct3_i == 3'b000 && funct7_i == 7'b0100000) begin
          dec_o.legal   = 1'b1;
          dec_o.cls     = CL_OP;
          dec_o.alu_sel = ALU_SUB;
        end
      end
      OPC_OPIMM: begin
        if (funct3_i == 3'b000) begin
          dec_o.legal   = 1'b1;
          dec_o.cls     = CL_ADDI;
          dec_o.alu_sel = ALU_ADDI;
          dec_o.src_b   = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3_i == 3'b010) begin
          dec_o.legal  = 1'b1;
          dec_o.cls    = CL_LW;
          dec_o.src_b  = 1'b1;
          dec_o.wb_sel = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (funct3_i == 3'b010) begin
          dec_o.legal = 1'b1;
          dec_o.cls   = CL_SW;
          dec_o.src_b = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec_o.src_a = 1'b1;
        dec_o.src_b = 1'b1;
        dec_o.legal = 1'b1;
        unique case (funct3_i)
          3'b000:  dec_o.cls = CL_BEQ;
          3'b001:  dec_o.cls = CL_BNE;
          3'b100:  dec_o.cls = CL_BLT;
          3'b110:  dec_o.cls = CL_BLTU;
          default: dec_o = '0;
        endcase
      end
      OPC_JAL: begin
        dec_o.legal  = 1'b1;
        dec_o.cls    = CL_JAL;
        dec_o.src_a  = 1'b1;
        dec_o.src_b  = 1'b1;
        dec_o.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3_i == 3'b000) begin
          dec_o.legal  = 1'b1;
          dec_o.cls    = CL_JALR;
          dec_o.src_b  = 1'b1;
          dec_o.wb_sel = WB_PC4;
        end
      end
      OPC_AUIPC: begin
        dec_o.legal = 1'b1;
        dec_o.cls   = CL_AUIPC;
        dec_o.src_a = 1'b1;
        dec_o.src_b = 1'b1;
      end
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle control FSM for the RISCV_2 datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of riscv_mc_control_if (memory handshakes,
//                IR, comparator flags in; ALUSel, selects, strobes,
//                sticky illegal/bus_err flags and debug state out)
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH; TRAP is terminal.
module riscv_mc_control
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst_n,
  riscv_mc_control_if.master bus
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  class_e        cls_q;
  logic [3:0]    alusel_q;
  logic          src_a_q, src_b_q;
  logic [1:0]    wb_sel_q;
  logic          rd_nz_q;

  dec_t          dec;
  logic          dec_we;
  logic          taken;
  logic          imem_req, ir_we, mem_re, mem_we, reg_we, pc_we;
  logic [1:0]    pc_src;
  logic          unused_ir;

  riscv_ctrl_decode u_decode (
    .opcode_i (bus.ir[6:0]),
    .funct3_i (bus.ir[14:12]),
    .funct7_i (bus.ir[31:25]),
    .dec_o    (dec)
  );

  assign unused_ir = ^bus.ir[XLEN-1:15];
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    taken = 1'b0;
    case (cls_q)
      CL_BEQ:  taken = bus.cmp_eq;
      CL_BNE:  taken = !bus.cmp_eq;
      CL_BLT:  taken = bus.cmp_lt;
      CL_BLTU: taken = bus.cmp_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Strobes are qualified by rst_n so they fall the moment reset asserts,
  // independent of the clock.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    dec_we    = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (bus.imem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (cnt_inc == TMO) begin
            bus_err_d = 1'b1;
            state_d   = ST_TRAP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DECODE: begin
          dec_we = 1'b1;
          if (dec.legal) begin
            state_d = ST_EXEC;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_TRAP;
          end
        end
        ST_EXEC: begin
          if (is_branch(cls_q)) begin
            pc_we   = 1'b1;
            pc_src  = taken ? PC_ALU : PC_PLUS4;
            state_d = ST_FETCH;
          end else if (cls_q == CL_LW || cls_q == CL_SW) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_re = (cls_q == CL_LW);
          mem_we = (cls_q == CL_SW);
          if (bus.dmem_ready) begin
            if (cls_q == CL_SW) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (cnt_inc == TMO) begin
            bus_err_d = 1'b1;
            state_d   = ST_TRAP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WB: begin
          reg_we = rd_nz_q;
          pc_we  = 1'b1;
          if (cls_q == CL_JAL)       pc_src = PC_ALU;
          else if (cls_q == CL_JALR) pc_src = PC_ALU_ALIGN;
          else                       pc_src = PC_PLUS4;
          state_d = ST_FETCH;
        end
        default: state_d = ST_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      cls_q     <= CL_NONE;
      alusel_q  <= ALU_ADD;
      src_a_q   <= 1'b0;
      src_b_q   <= 1'b0;
      wb_sel_q  <= WB_ALU;
      rd_nz_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      if (dec_we) begin
        cls_q    <= dec.cls;
        alusel_q <= dec.alu_sel;
        src_a_q  <= dec.src_a;
        src_b_q  <= dec.src_b;
        wb_sel_q <= dec.wb_sel;
        rd_nz_q  <= (bus.ir[11:7] != 5'd0);
      end
    end
  end

  // During DECODE the fresh decode is shown directly; afterwards the
  // registered copy holds it until the next DECODE.
  assign bus.ALUSel    = (state_q == ST_DECODE) ? dec.alu_sel : alusel_q;
  assign bus.alu_src_a = (state_q == ST_DECODE) ? dec.src_a   : src_a_q;
  assign bus.alu_src_b = (state_q == ST_DECODE) ? dec.src_b   : src_b_q;
  assign bus.wb_sel    = (state_q == ST_DECODE) ? dec.wb_sel  : wb_sel_q;

  assign bus.imem_req = imem_req;
  assign bus.ir_we    = ir_we;
  assign bus.mem_re   = mem_re;
  assign bus.mem_we   = mem_we;
  assign bus.reg_we   = reg_we;
  assign bus.pc_we    = pc_we;
  assign bus.pc_src   = pc_src;
  assign bus.illegal  = illegal_q;
  assign bus.bus_err  = bus_err_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed self-checking bench for riscv_mc_control.
module tb_riscv_mc_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_mc_control_if #(.XLEN(32)) bus ();

  riscv_mc_control #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Held decode values expected on ALUSel/selects/wb_sel between DECODEs.
  logic [3:0] h_alu;
  logic       h_a, h_b;
  logic [1:0] h_wb;

  typedef logic [20:0] snap_t;

  function automatic snap_t obs();
    return {bus.imem_req, bus.ir_we, bus.ALUSel, bus.alu_src_a, bus.alu_src_b,
            bus.mem_re, bus.mem_we, bus.reg_we, bus.wb_sel, bus.pc_we,
            bus.pc_src, bus.illegal, bus.bus_err, bus.state_o};
  endfunction

  function automatic snap_t exp_s(logic req, logic irwe, logic [3:0] alu,
                                  logic a, logic b, logic re, logic we,
                                  logic rwe, logic [1:0] wb, logic pwe,
                                  logic [1:0] ps, logic ill, logic be,
                                  logic [2:0] st);
    return {req, irwe, alu, a, b, re, we, rwe, wb, pwe, ps, ill, be, st};
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        a;
    logic        b;
    logic [1:0]  wb;
    logic        rwe;
    logic [1:0]  ps;
  } avec_t;

  avec_t av [8] = '{
    '{32'h002081B3, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0},  // add x3,x1,x2
    '{32'h402081B3, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0},  // sub x3,x1,x2
    '{32'h00508093, 4'b0010, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0},  // addi x1,x1,5
    '{32'h00001397, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0},  // auipc x7,1
    '{32'h000000EF, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1},  // jal x1,0
    '{32'h000280E7, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2},  // jalr x1,0(x5)
    '{32'h00028067, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2},  // jalr x0,0(x5)
    '{32'h00208033, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}   // add x0,x1,x2
  };

  typedef struct packed {
    logic [31:0] instr;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        taken;
  } bvec_t;

  bvec_t bv [8] = '{
    '{32'h00208463, 1'b1, 1'b0, 1'b0, 1'b1},  // beq  taken
    '{32'h00208463, 1'b0, 1'b1, 1'b1, 1'b0},  // beq  not taken
    '{32'h00209463, 1'b0, 1'b0, 1'b0, 1'b1},  // bne  taken
    '{32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0},  // bne  not taken
    '{32'h0020C463, 1'b0, 1'b1, 1'b0, 1'b1},  // blt  taken
    '{32'h0020C463, 1'b1, 1'b0, 1'b1, 1'b0},  // blt  not taken
    '{32'h0020E463, 1'b0, 1'b0, 1'b1, 1'b1},  // bltu taken
    '{32'h0020E463, 1'b0, 1'b1, 1'b0, 1'b0}   // bltu not taken
  };

  localparam logic [31:0] LW_X5 = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] SW_X5 = 32'h0050A023;  // sw x5,0(x1)
  localparam logic [31:0] BAD   = 32'h0000007F;

  // Inputs change and outputs are sampled a few ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    snap_t e;
    rst_n = 1'b1;
    bus.ir = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    bus.cmp_eq = 1'b0; bus.cmp_lt = 1'b0; bus.cmp_ltu = 1'b0;
    h_alu = 4'd0; h_a = 1'b0; h_b = 1'b0; h_wb = 2'd0;
    #1 rst_n = 1'b0;
    #2;
    e = exp_s(0,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs(), e); end
    #10;
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs(), e); end
    rst_n = 1'b1;
    #1;
    e = exp_s(1,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs(), e); end
  endtask

  task automatic test_alu_class();
    snap_t e;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus.ir = av[i].instr; bus.imem_ready = 1'b1;
      #1;
      e = exp_s(1,1,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd0);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL alu%0d_fetch: got %b expected %b", i, obs(), e); end
      next_cycle();
      bus.imem_ready = 1'b0;
      #1;
      e = exp_s(0,0,av[i].alu,av[i].a,av[i].b,0,0,0,av[i].wb,0,2'd0,0,0,3'd1);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL alu%0d_decode: got %b expected %b", i, obs(), e); end
      h_alu = av[i].alu; h_a = av[i].a; h_b = av[i].b; h_wb = av[i].wb;
      next_cycle();
      #1;
      e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd2);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL alu%0d_exec: got %b expected %b", i, obs(), e); end
      next_cycle();
      #1;
      e = exp_s(0,0,h_alu,h_a,h_b,0,0,av[i].rwe,h_wb,1,av[i].ps,0,0,3'd4);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL alu%0d_wb: got %b expected %b", i, obs(), e); end
    end
  endtask

  task automatic test_branch();
    snap_t e;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus.ir = bv[i].instr; bus.imem_ready = 1'b1;
      #1;
      e = exp_s(1,1,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd0);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL br%0d_fetch: got %b expected %b", i, obs(), e); end
      next_cycle();
      bus.imem_ready = 1'b0;
      bus.cmp_eq = bv[i].eq; bus.cmp_lt = bv[i].lt; bus.cmp_ltu = bv[i].ltu;
      #1;
      h_alu = 4'd0; h_a = 1'b1; h_b = 1'b1; h_wb = 2'd0;
      e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd1);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL br%0d_decode: got %b expected %b", i, obs(), e); end
      next_cycle();
      #1;
      e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,1,{1'b0, bv[i].taken},0,0,3'd2);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL br%0d_exec: got %b expected %b", i, obs(), e); end
    end
    bus.cmp_eq = 1'b0; bus.cmp_lt = 1'b0; bus.cmp_ltu = 1'b0;
  endtask

  task automatic test_lw();
    snap_t e;
    int re_cycles;
    next_cycle();
    bus.ir = LW_X5; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    #1;
    e = exp_s(1,1,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL lw_fetch: got %b expected %b", obs(), e); end
    next_cycle();
    bus.imem_ready = 1'b0;
    #1;
    h_alu = 4'd0; h_a = 1'b0; h_b = 1'b1; h_wb = 2'd1;
    e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd1);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL lw_decode: got %b expected %b", obs(), e); end
    next_cycle();
    #1;
    e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd2);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL lw_exec: got %b expected %b", obs(), e); end
    re_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.dmem_ready = (k == 3);
      #1;
      if (bus.mem_re === 1'b1) re_cycles++;
      e = exp_s(0,0,h_alu,h_a,h_b,1,0,0,h_wb,0,2'd0,0,0,3'd3);
      n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL lw_mem%0d: got %b expected %b", k, obs(), e); end
    end
    next_cycle();
    bus.dmem_ready = 1'b0;
    #1;
    e = exp_s(0,0,h_alu,h_a,h_b,0,0,1,h_wb,1,2'd0,0,0,3'd4);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL lw_wb: got %b expected %b", obs(), e); end
    n_checks++; if (re_cycles !== 4) begin n_fail++; $display("FAIL lw_re_cycles: got %0d expected 4", re_cycles); end
  endtask

  task automatic test_sw();
    snap_t e;
    next_cycle();
    bus.ir = SW_X5; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    #1;
    next_cycle();
    bus.imem_ready = 1'b0;
    #1;
    h_alu = 4'd0; h_a = 1'b0; h_b = 1'b1; h_wb = 2'd0;
    e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd1);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL sw_decode: got %b expected %b", obs(), e); end
    next_cycle();
    #1;
    next_cycle();
    bus.dmem_ready = 1'b1;
    #1;
    e = exp_s(0,0,h_alu,h_a,h_b,0,1,0,h_wb,1,2'd0,0,0,3'd3);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL sw_mem_ready: got %b expected %b", obs(), e); end
    next_cycle();
    bus.dmem_ready = 1'b0;
    #1;
    e = exp_s(1,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL sw_refetch: got %b expected %b", obs(), e); end
  endtask

  task automatic test_illegal();
    snap_t e;
    next_cycle();
    bus.ir = BAD; bus.imem_ready = 1'b1;
    #1;
    next_cycle();
    #1;
    e = exp_s(0,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd1);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ill_decode: got %b expected %b", obs(), e); end
    next_cycle();
    #1;
    e = exp_s(0,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,1,0,3'd5);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ill_trap: got %b expected %b", obs(), e); end
    for (int k = 0; k < 3; k++) next_cycle();
    #1;
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ill_trap_held: got %b expected %b", obs(), e); end
    rst_n = 1'b0;
    #1;
    e = exp_s(0,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL ill_reset: got %b expected %b", obs(), e); end
    next_cycle();
    bus.imem_ready = 1'b0;
    rst_n = 1'b1;
    h_alu = 4'd0; h_a = 1'b0; h_b = 1'b0; h_wb = 2'd0;
  endtask

  task automatic test_timeout();
    snap_t e;
    next_cycle();
    bus.ir = LW_X5; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    #1;
    next_cycle();
    bus.imem_ready = 1'b0;
    #1;
    next_cycle();
    #1;
    h_alu = 4'd0; h_a = 1'b0; h_b = 1'b1; h_wb = 2'd1;
    e = exp_s(0,0,h_alu,h_a,h_b,1,0,0,h_wb,0,2'd0,0,0,3'd3);
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      #1;
      if (k == 1 || k == 16) begin
        n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL tmo_wait%0d: got %b expected %b", k, obs(), e); end
      end
    end
    next_cycle();
    #1;
    e = exp_s(0,0,h_alu,h_a,h_b,0,0,0,h_wb,0,2'd0,0,1,3'd5);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL tmo_trap: got %b expected %b", obs(), e); end
    next_cycle();
    bus.dmem_ready = 1'b1;
    #1;
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL tmo_trap_held: got %b expected %b", obs(), e); end
    bus.dmem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    next_cycle();
    rst_n = 1'b1;
    h_alu = 4'd0; h_a = 1'b0; h_b = 1'b0; h_wb = 2'd0;
  endtask

  task automatic test_reset_mid_mem();
    snap_t e;
    next_cycle();
    bus.ir = LW_X5; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    #1;
    next_cycle();
    bus.imem_ready = 1'b0;
    #1;
    next_cycle();
    #1;
    next_cycle();
    #1;
    next_cycle();
    #1;
    e = exp_s(0,0,4'd0,0,1,1,0,0,2'd1,0,2'd0,0,0,3'd3);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rmm_in_mem: got %b expected %b", obs(), e); end
    rst_n = 1'b0;
    #1;
    e = exp_s(0,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rmm_async_drop: got %b expected %b", obs(), e); end
    bus.dmem_ready = 1'b1;
    next_cycle();
    #1;
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rmm_held: got %b expected %b", obs(), e); end
    bus.dmem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    e = exp_s(1,0,4'd0,0,0,0,0,0,2'd0,0,2'd0,0,0,3'd0);
    n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL rmm_release: got %b expected %b", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_alu_class();
    test_branch();
    test_lw();
    test_sw();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multi-cycle control FSM for the RISCV_2 datapath; it is the driving end of the ALU's ALUSel interface.
- Fetches each instruction, decodes it, and issues ALUSel, operand-select, memory, PC and register-file strobes over several cycles.
- Branch conditions come from an external register comparator; the ALU only computes add/sub/addi results and addresses.
- Sits between instruction/data memory handshakes and the datapath (PC, IR, regfile, immgen, ALU).

Parameters:
- XLEN, 32, instruction/data width.
- MEM_TIMEOUT, 16, maximum cycles to wait for imem_ready/dmem_ready before trapping; minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  XLEN  instruction register contents; valid from DECODE onward.
- imem_ready  in  1  instruction memory has data; IR captures it when ir_we=1.
- dmem_ready  in  1  data memory access complete.
- cmp_eq, cmp_lt, cmp_ltu  in  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load strobe.
- ALUSel  out  4  ALU operation; 0000 add, 0001 sub, 0010 addi. No other code is emitted.
- alu_src_a  out  1  0 = rs1, 1 = PC.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- mem_re, mem_we  out  1 each  data memory read/write request.
- reg_we  out  1  regfile write strobe.
- wb_sel  out  2  0 = ALU result, 1 = memory data, 2 = PC+4.
- pc_we  out  1  PC load strobe.
- pc_src  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result with bit0 cleared.
- illegal  out  1  sticky trap flag.
- bus_err  out  1  sticky timeout flag.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - state = FETCH.
  - All strobes = 0; ALUSel = 0000; selects = 0; illegal = bus_err = 0; timeout counter = 0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_we=1 for exactly that cycle, then go to DECODE.
  - Counter increments each waiting cycle; reaching MEM_TIMEOUT sets bus_err and goes to TRAP.
- DECODE (1 cycle):
  - Classify opcode/funct3/funct7; register ALUSel, selects, wb_sel and class. These stay held until the next DECODE.
  - R-type 0110011, f3=000: funct7 0000000 gives 0000; funct7 0100000 gives 0001.
  - addi 0010011/000: 0010, src_b=1.
  - lw 0000011/010 and sw 0100011/010: 0000, src_b=1.
  - Branch 1100011 with f3 000/001/100/110 (beq/bne/blt/bltu): 0000, src_a=1, src_b=1.
  - jal 1101111: 0000, src_a=1, src_b=1.
  - jalr 1100111/000: 0000, src_b=1.
  - auipc 0010111: 0000, src_a=1, src_b=1 (immgen supplies the pre-shifted immediate).
  - Anything else: set illegal and go to TRAP.
- EXEC (1 cycle):
  - Branch: taken = eq / !eq / lt / ltu per f3. pc_we=1, pc_src = taken ? 1 : 0, then go to FETCH.
  - lw/sw: go to MEM.
  - All other classes: go to WB.
- MEM:
  - mem_re (lw) or mem_we (sw) held high until dmem_ready=1.
  - sw: on ready, pc_we=1, pc_src=0, go to FETCH.
  - lw: on ready, go to WB.
  - Timeout behaves as in FETCH.
- WB (1 cycle):
  - reg_we=1 unless rd=x0.
  - wb_sel: 1 for lw, 2 for jal/jalr, 0 otherwise.
  - pc_we=1 with pc_src: 1 for jal, 2 for jalr, 0 otherwise.
  - Then go to FETCH.
- TRAP:
  - All strobes 0; stays in TRAP until reset.
  - illegal and bus_err are never cleared except by reset.
- Strobes:
  - ir_we, reg_we, pc_we are single-cycle pulses; exactly one pc_we per retired instruction.
  - mem_re and mem_we are never both high.
  - ready arriving the same cycle the request is first raised completes that same cycle.
  - Counter resets to 0 on every state change.
- Reset mid-MEM: strobes drop asynchronously; no pc_we or reg_we is issued.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - ALUSel codes ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_ADDI=4'b0010;
  - state encoding, wb_sel codes and pc_src codes.
- One sub-module, riscv_ctrl_decode: purely combinational ir → class/ALUSel/selects/legal.
- The FSM and timeout counter live in riscv_mc_control.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ready held 1 → ir_we in cycle 1; ALUSel=0000 from DECODE; reg_we=1, wb_sel=0, pc_we=1, pc_src=0 in cycle 4; back in FETCH in cycle 5.
- sub 0x402081B3 → ALUSel=0001. addi 0x00508093 → ALUSel=0010, src_b=1, reg_we in WB.
- beq with cmp_eq=1 → EXEC: pc_we=1, pc_src=1, no reg_we. With cmp_eq=0 → pc_src=0. Repeat for bne, blt, bltu using the cmp inputs.
- lw with dmem_ready delayed 3 cycles → mem_re high 4 cycles; WB: wb_sel=1. sw → mem_we, no reg_we, pc_we at ready.
- jalr x1,0(x5) → WB: reg_we=1, wb_sel=2, pc_src=2. Same with rd=x0 → reg_we=0.
- Each trap and reset case:
  - Opcode 0x7F → illegal=1, TRAP held.
  - dmem_ready never asserted with MEM_TIMEOUT=16 → bus_err=1 after 16 cycles.
  - rst_n pulsed low mid-MEM → all outputs 0 immediately, state FETCH.
